// File: rtl/dwc_error_monitor.sv
// -----------------------------------------------------------------------------
// dwc_error_monitor
//
// Watches the result of a duplicate-with-compare (DwC) stage. Samples whose
// comparator result shows agreement are forwarded as "last good" data.
// Disagreements are counted. THRESH back-to-back disagreements latch a sticky
// fault, and only port_clear releases it. Valid-idle cycles do not break a
// streak.
//
// Parameters
//   WIDTH     : data width of the duplicated path
//   ERR_LEVEL : port_error level that signals a mismatch
//   THRESH    : consecutive mismatches that declare a fault (1..255)
//   CNT_W     : width of the saturating mismatch counter
//
// Ports
//   port_clk       in   sole clock, rising edge
//   port_rst_n     in   asynchronous active-low reset
//   port_valid     in   port_in / port_error carry a sample this cycle
//   port_in        in   primary-copy data [WIDTH]
//   port_error     in   DwC comparator result
//   port_clear     in   synchronous fault / counter clear (beats a sample)
//   port_out       out  registered last-good data [WIDTH]
//   port_out_valid out  one-cycle strobe, port_out was just updated
//   port_fault     out  sticky fault flag
//   port_err_count out  saturating total mismatch count [CNT_W]
// -----------------------------------------------------------------------------
module dwc_error_monitor #(
  parameter int   WIDTH     = 1,
  parameter logic ERR_LEVEL = 1'b0,
  parameter int   THRESH    = 3,
  parameter int   CNT_W     = 8
) (
  input  logic             port_clk,
  input  logic             port_rst_n,
  input  logic             port_valid,
  input  logic [WIDTH-1:0] port_in,
  input  logic             port_error,
  input  logic             port_clear,
  output logic [WIDTH-1:0] port_out,
  output logic             port_out_valid,
  output logic             port_fault,
  output logic [CNT_W-1:0] port_err_count
);

  localparam int STRK_W = $clog2(THRESH + 1);
  localparam logic [STRK_W-1:0] THRESH_C = STRK_W'(THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [STRK_W-1:0]  streak_r;
  logic [STRK_W-1:0]  streak_nxt_s;
  logic [STRK_W-1:0]  streak_inc_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [WIDTH-1:0]   out_r;
  logic               out_valid_r;
  logic               fault_r;
  logic               mismatch_s;
  logic               match_s;
  logic               fwd_s;
  logic               count_inc_s;

  assign mismatch_s   = port_valid && (port_error == ERR_LEVEL);
  assign match_s      = port_valid && !mismatch_s;
  assign streak_inc_s = streak_r + STRK_W'(1);

  // Next-state, streak and forward/count decisions; clear overrides any sample
  always_comb begin
    state_nxt_s  = state_r;
    streak_nxt_s = streak_r;
    fwd_s        = 1'b0;
    count_inc_s  = 1'b0;
    if (port_clear) begin
      state_nxt_s  = ST_OK;
      streak_nxt_s = '0;
    end else begin
      case (state_r)
        ST_OK: begin
          if (mismatch_s) begin
            count_inc_s  = 1'b1;
            streak_nxt_s = STRK_W'(1);
            if (THRESH == 1) begin
              state_nxt_s = ST_FAULT;
            end else begin
              state_nxt_s = ST_SUSPECT;
            end
          end else if (match_s) begin
            fwd_s = 1'b1;
          end else begin
            state_nxt_s = ST_OK;
          end
        end
        ST_SUSPECT: begin
          if (mismatch_s) begin
            count_inc_s  = 1'b1;
            streak_nxt_s = streak_inc_s;
            if (streak_inc_s == THRESH_C) begin
              state_nxt_s = ST_FAULT;
            end else begin
              state_nxt_s = ST_SUSPECT;
            end
          end else if (match_s) begin
            fwd_s        = 1'b1;
            state_nxt_s  = ST_OK;
            streak_nxt_s = '0;
          end else begin
            state_nxt_s = ST_SUSPECT;
          end
        end
        ST_FAULT: begin
          // Samples are ignored entirely until cleared
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s  = ST_OK;
          streak_nxt_s = '0;
        end
      endcase
    end
  end

  // Saturating mismatch counter next value
  always_comb begin
    count_nxt_s = count_r;
    if (port_clear) begin
      count_nxt_s = '0;
    end else if (count_inc_s && (count_r != CNT_MAX)) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Control state: FSM, streak and error counter
  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      state_r  <= ST_OK;
      streak_r <= '0;
      count_r  <= '0;
    end else begin
      state_r  <= state_nxt_s;
      streak_r <= streak_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Output registers; fault mirrors the registered FAULT state
  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      out_valid_r <= fwd_s;
      fault_r     <= (state_nxt_s == ST_FAULT);
      if (fwd_s) begin
        out_r <= port_in;
      end
    end
  end

  assign port_out       = out_r;
  assign port_out_valid = out_valid_r;
  assign port_fault     = fault_r;
  assign port_err_count = count_r;

endmodule

// File: doc/dwc_error_monitor.md
DWC_ERROR_MONITOR -- requirements
Module: dwc_error_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width of the duplicated path.
REQ-002 SHALL have parameter ERR_LEVEL, default 1'b0, the port_error level that signals a mismatch.
REQ-003 SHALL have parameter THRESH, default 3, consecutive mismatches that declare a fault (legal range 1..255).
REQ-004 SHALL have parameter CNT_W, default 8, width of the error counter.
REQ-005 SHALL have port_clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port_valid  input  1  port_in/port_error carry a sample this cycle.
REQ-008 SHALL have port_in  input  WIDTH  primary-copy data from the DwC stage.
REQ-009 SHALL have port_error  input  1  DwC comparator result.
REQ-010 SHALL have port_clear  input  1  synchronous fault/counter clear.
REQ-011 SHALL have port_out  output  WIDTH  registered last-good data.
REQ-012 SHALL have port_out_valid  output  1  one-cycle strobe, port_out updated.
REQ-013 SHALL have port_fault  output  1  sticky fault flag.
REQ-014 SHALL have port_err_count  output  CNT_W  saturating total mismatch count.

Function
REQ-015 SHALL define mismatch = port_valid && (port_error == ERR_LEVEL); match = port_valid && !mismatch.
REQ-016 SHALL implement FSM states OK, SUSPECT, FAULT, plus streak counter of width ceil(log2(THRESH+1)).
REQ-017 SHALL, in OK: mismatch -> SUSPECT with streak=1, or directly FAULT if THRESH==1; otherwise stay.
REQ-018 SHALL, in SUSPECT: mismatch -> streak+1, entering FAULT when streak+1==THRESH; match -> OK with streak=0; no valid -> hold.
REQ-019 SHALL, in FAULT: remain until port_clear, ignoring all samples (no forward, no count).
REQ-020 SHALL drive port_fault high exactly while state==FAULT, asserted the cycle after the triggering sample.
REQ-021 SHALL, on match in OK or SUSPECT, load port_out<=port_in and pulse port_out_valid for one cycle (latency 1).
REQ-022 SHALL, on mismatch, hold port_out unchanged and keep port_out_valid low.
REQ-023 SHALL increment port_err_count on each counted mismatch, saturating at 2^CNT_W-1 (no wrap).
REQ-024 SHALL, on port_clear, go to OK, zero streak and port_err_count, drop port_fault next cycle; port_out keeps its value.
REQ-025 SHALL give port_clear priority over a same-cycle sample: that sample is neither counted, forwarded, nor advances the FSM.
REQ-026 SHALL keep port_out_valid low whenever port_valid is low.

Reset
REQ-027 SHALL, while port_rst_n low, force state=OK, streak=0, port_out=0, port_out_valid=0, port_fault=0, port_err_count=0, independent of port_clk.
REQ-028 SHALL abandon any in-progress streak or fault on reset mid-operation; first post-reset sample is evaluated from OK.
REQ-029 SHALL release reset synchronously to internal logic (no action on the release edge other than normal sampling).

Verification (WIDTH=1, ERR_LEVEL=0, THRESH=3, CNT_W=8)
REQ-030 SHALL cover: reset low then high, valid=1,in=1,error=1 -> next cycle out=1, out_valid=1, fault=0, count=0.
REQ-031 SHALL cover: two mismatches then one match -> count=2, fault=0, out updated only on the match, state back to OK.
REQ-032 SHALL cover: three consecutive mismatches (gaps with valid=0 allowed) -> fault=1 after third, count=3; further samples -> count stays 3, no out_valid.
REQ-033 SHALL cover: in FAULT, clear=1 together with a mismatch -> fault=0, count=0, next mismatch gives count=1.
REQ-034 SHALL cover: 300 mismatches with clear pulsed every 2 samples disabled by THRESH=255 override -> count saturates at 255.
REQ-035 SHALL cover: rst_n asserted asynchronously mid-SUSPECT (between clock edges) -> all outputs 0 immediately; two post-reset mismatches leave fault=0.
